l1_cache: RTL
=============

Name: l1_cache

Overview:
- Direct-mapped, write-back, write-allocate cache between the LC-3b CPU memory port and the physical memory model.
- CPU side uses the CPU's existing 16-bit word handshake (mem_read/mem_write/mem_resp with byte enables).
- Memory side moves whole 128-bit lines over a pmem_* handshake.
- Hits complete in one cycle; misses run a writeback and/or allocate sequence before completing.

Parameters:
- S_INDEX, 3, log2 of set count (8 sets); tag width = 12 - S_INDEX (9 bits at default); line is fixed at 16 bytes.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2  write byte mask; bit0 = low byte, bit1 = high byte
- mem_address  in  16  CPU byte address; bit0 ignored (word access)
- mem_wdata  in  16  CPU write data
- mem_resp  out  1  one-cycle completion pulse to CPU
- mem_rdata  out  16  read data, valid while mem_resp=1
- pmem_resp  in  1  physical memory completion
- pmem_rdata  in  128  fill line
- pmem_read  out  1  line read request
- pmem_write  out  1  line write request
- pmem_address  out  16  line address, bits [3:0] = 0
- pmem_wdata  out  128  evicted line

Behaviour:
- Address split: offset = [3:0], word select = [3:1], index = [3+S_INDEX:4], tag = [15:4+S_INDEX].
- Per-set state: valid, dirty, tag, 128-bit data. Reset clears all valid and dirty bits. Tags and data are not cleared.
- Outputs are combinational from state and inputs. During reset and in IDLE with no request: mem_resp=0, pmem_read=0, pmem_write=0. mem_rdata, pmem_address and pmem_wdata are don't-care when their strobes are low.
- FSM states:
  - IDLE: request = mem_read | mem_write. hit = valid[index] & (tag[index] == tag).
    - Hit: mem_resp=1 this cycle. A read returns word [word select] of the line. A write merges enabled bytes into that word at the clock edge and sets dirty. Stay in IDLE.
    - Miss, dirty victim: go to WRITEBACK.
    - Miss, clean victim: go to ALLOCATE.
  - WRITEBACK: pmem_write=1, pmem_address = {stored tag, index, 4'b0}, pmem_wdata = stored line. On pmem_resp, clear dirty and go to ALLOCATE.
  - ALLOCATE: pmem_read=1, pmem_address = {req tag, index, 4'b0}. On pmem_resp, write pmem_rdata into data, set tag, valid=1, dirty=0, and go to IDLE, where the request now hits.
- mem_resp is never asserted outside IDLE. Latency:
  - Hit: 1 cycle.
  - Clean miss: 1 + allocate wait + 1.
  - Dirty miss: adds the writeback wait.
- pmem strobes stay high, with stable address and data, until pmem_resp. Each state issues exactly one transaction.
- mem_read and mem_write both high is illegal; the cache treats it as a write.
- A write with mem_byte_enable = 2'b00 on a hit still responds and sets dirty; data is unchanged.
- Reset mid-operation: FSM goes to IDLE on the next edge. pmem strobes drop that cycle. Valid and dirty are cleared. The outstanding pmem transaction is abandoned.
- A request change while in WRITEBACK or ALLOCATE is a CPU protocol violation; behaviour is undefined.

Decomposition:
- Add to lc3b_types:
  - lc3b_c_line (128-bit)
  - lc3b_c_tag
  - lc3b_c_index
  - lc3b_c_offset
  - S_INDEX default constant
- Sub-module l1_cache_control: the FSM, taking hit, dirty and request inputs and driving state-dependent strobes and load enables.
- Arrays, tag compare and byte merge stay in the top level.

Test Plan:
- Reset, then read 0x0042. Expect a clean miss: pmem_read with pmem_address=0x0040. Return a line whose word1 is 0xBEEF. One cycle after pmem_resp, mem_resp=1 with mem_rdata=0xBEEF, and pmem_write is never asserted.
- Read 0x0044 after the previous test. Expect a hit: mem_resp in the same cycle, data = word2 of the same line, no pmem activity.
- Write 0x0042 with data 0x1234 and byte_enable 2'b01. Expect mem_resp in 1 cycle; a follow-up read of 0x0042 returns 0xBE34.
- Read 0x0842, which maps to the same index with a different tag. Expect pmem_write first with pmem_address=0x0040 and a line containing 0xBE34 at word1. Then pmem_read at 0x0840. Then mem_resp with the new data.
- Assert reset while in ALLOCATE, holding pmem_resp low. pmem_read must drop the cycle reset is sampled. After reset, a read of 0x0842 misses again, since valid was cleared.
- Stall pmem_resp for 10 cycles during WRITEBACK. pmem_write, pmem_address and pmem_wdata must stay stable for all 10 cycles, and mem_resp must stay 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions, including the L1 cache line/tag/index types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lc3b_types;

  // Default log2 of the L1 set count (8 sets).
  localparam int L1_S_INDEX = 3;

  // A cache line is always 16 bytes (eight 16-bit words).
  typedef logic [127:0]              lc3b_c_line;
  typedef logic [12-L1_S_INDEX-1:0]  lc3b_c_tag;
  typedef logic [L1_S_INDEX-1:0]     lc3b_c_index;
  typedef logic [3:0]                lc3b_c_offset;

  // Cache controller states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } cache_state_e;

endpackage

// File: rtl/l1_cache_control.sv
// L1 cache controller FSM: hit service, dirty-victim writeback, line allocate.
// Latency: hits respond in the request cycle; misses add one state per pmem transaction.
// Backpressure: pmem strobes are held until pmem_resp_i; CPU sees no resp until the line is resident.
module l1_cache_control
  import lc3b_types::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic req_i,          // CPU read or write pending
  input  logic write_i,        // request is a write (wins if read also set)
  input  logic hit_i,          // indexed line is valid and tag matches
  input  logic dirty_i,        // indexed line is dirty
  input  logic pmem_resp_i,
  output logic mem_resp_o,
  output logic pmem_read_o,
  output logic pmem_write_o,
  output logic load_word_o,    // merge CPU write data into the indexed line
  output logic load_line_o,    // install fill line, tag, valid; clear dirty
  output logic clear_dirty_o,  // writeback finished
  output logic victim_sel_o    // pmem address uses the stored tag
);

  cache_state_e state_q, state_d;

  // State register; reset abandons any outstanding pmem transaction.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; everything is forced quiet while reset is high.
  always_comb begin
    state_d       = state_q;
    mem_resp_o    = 1'b0;
    pmem_read_o   = 1'b0;
    pmem_write_o  = 1'b0;
    load_word_o   = 1'b0;
    load_line_o   = 1'b0;
    clear_dirty_o = 1'b0;
    victim_sel_o  = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            if (hit_i) begin
              mem_resp_o  = 1'b1;
              load_word_o = write_i;
            end else if (dirty_i) begin
              state_d = ST_WRITEBACK;
            end else begin
              state_d = ST_ALLOCATE;
            end
          end
        end
        ST_WRITEBACK: begin
          pmem_write_o = 1'b1;
          victim_sel_o = 1'b1;
          if (pmem_resp_i) begin
            clear_dirty_o = 1'b1;
            state_d       = ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          pmem_read_o = 1'b1;
          if (pmem_resp_i) begin
            load_line_o = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1 cache between the LC-3b CPU port and line-wide pmem.
// Latency: hit 1 cycle; clean miss 1 + allocate wait + 1; dirty miss also adds the writeback wait.
// Backpressure: CPU request is held until mem_resp; pmem strobes/address/data are held until pmem_resp.
module l1_cache
  import lc3b_types::*;
#(
  parameter int S_INDEX = L1_S_INDEX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata
);

  localparam int TAG_W = 12 - S_INDEX;
  localparam int NSETS = 1 << S_INDEX;

  // Address split.
  lc3b_c_offset       offset;
  logic [2:0]         word_sel;
  logic [S_INDEX-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic               unused_byte_lsb;

  assign offset          = mem_address[3:0];
  assign word_sel        = offset[3:1];
  assign unused_byte_lsb = offset[0];  // word accesses only
  assign idx             = mem_address[3+S_INDEX:4];
  assign req_tag         = mem_address[15:4+S_INDEX];

  // Per-set state. Tags and data have no reset; valid gates their use.
  logic [NSETS-1:0] valid_q, valid_d;
  logic [NSETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q  [NSETS];
  lc3b_c_line       data_q [NSETS];

  // Controller handshake.
  logic req, hit;
  logic load_word, load_line, clear_dirty, victim_sel;

  assign req = mem_read | mem_write;
  assign hit = valid_q[idx] & (tag_q[idx] == req_tag);

  l1_cache_control u_control (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_i         (req),
    .write_i       (mem_write),
    .hit_i         (hit),
    .dirty_i       (dirty_q[idx]),
    .pmem_resp_i   (pmem_resp),
    .mem_resp_o    (mem_resp),
    .pmem_read_o   (pmem_read),
    .pmem_write_o  (pmem_write),
    .load_word_o   (load_word),
    .load_line_o   (load_line),
    .clear_dirty_o (clear_dirty),
    .victim_sel_o  (victim_sel)
  );

  // Selected line and bit positions of the addressed word's two bytes.
  lc3b_c_line cur_line, merged_line, line_d;
  logic [6:0] lo_base, hi_base;

  assign cur_line = data_q[idx];
  assign lo_base  = {word_sel, 4'b0000};
  assign hi_base  = {word_sel, 4'b1000};

  // Byte-enable merge of CPU write data into the addressed word.
  always_comb begin
    merged_line = cur_line;
    if (mem_byte_enable[0]) merged_line[lo_base +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_line[hi_base +: 8] = mem_wdata[15:8];
  end

  // A fill replaces the whole line; otherwise the merged word is stored.
  assign line_d = load_line ? pmem_rdata : merged_line;

  // Read data and memory-side address/data.
  assign mem_rdata    = cur_line[lo_base +: 16];
  assign pmem_wdata   = cur_line;
  assign pmem_address = victim_sel ? {tag_q[idx], idx, 4'b0000}
                                   : {req_tag,    idx, 4'b0000};

  // Valid/dirty next state for the indexed set.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (clear_dirty) dirty_d[idx] = 1'b0;
    if (load_line) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
    if (load_word) dirty_d[idx] = 1'b1;
  end

  // Valid/dirty registers; reset invalidates the whole cache.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays; load strobes are already quiet during reset.
  always_ff @(posedge clk) begin
    if (load_line || load_word) data_q[idx] <= line_d;
    if (load_line)              tag_q[idx]  <= req_tag;
  end

endmodule
